seg7_scan: RTL

Multiplexed seven-segment display driver for the calculator front panel. It is the output-side counterpart to the debounced button inputs. It latches a hex value and a decimal-point mask on a load strobe, time-multiplexes the digits onto a shared segment bus, and applies PWM brightness within each digit slot. It sits between the calculator core (value producer) and the board's display pins.

---
 rtl/seg7_pkg.sv | 15 +
 rtl/seg7_scan_if.sv | 37 +++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan.sv | 104 ++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the hex-digit segment font for the front-panel display driver.
// Patterns are active-high with bit0 = segment a through bit6 = segment g.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    // 0-9, A, b, C, d, E, F (b and d lowercase so they differ from 8 and 0)
    localparam seg7_t SEG7_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_scan_if.sv
// Core-to-display bundle: latched value/dp/brightness in, multiplexed pin drive out.
// The core side uses master and the scan driver uses slave.
interface seg7_scan_if
    import seg7_pkg::*;
#(
    parameter int DIGITS = 8
);

    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic                load;
    logic [3:0]          bright;
    seg7_t               seg;
    logic                dp_out;
    logic [DIGITS-1:0]   an;

    modport master (
        output value,
        output dp,
        output load,
        output bright,
        input  seg,
        input  dp_out,
        input  an
    );

    modport slave (
        input  value,
        input  dp,
        input  load,
        input  bright,
        output seg,
        output dp_out,
        output an
    );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to seven-segment pattern lookup, active-high, zero latency.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    assign seg = SEG7_HEX[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment driver with per-slot PWM; outputs registered, one cycle after state.
// No backpressure: a load strobe is always accepted. SEG7_ZERO_BLANK_EN enables leading-zero blanking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 16,
    parameter int ACTIVE_LOW = 1
)(
    input  logic       clk,
    input  logic       rst,
    seg7_scan_if.slave bus
);

    localparam int            IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
    localparam logic          INV  = (ACTIVE_LOW != 0);

    logic [SCAN_DIV-1:0] slot_cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] val_q;
    logic [DIGITS-1:0]   dp_q;

    logic [4*DIGITS-1:0] val_shift;
    logic [DIGITS-1:0]   dp_shift;
    logic [3:0]          nibble;
    seg7_t               dec_seg;
    logic                lit;
    logic                blank;
    logic [DIGITS-1:0]   an_hot;

    seg7_t               seg_nxt;
    logic                dp_nxt;
    logic [DIGITS-1:0]   an_nxt;

    seg7_t               seg_q;
    logic                dp_out_q;
    logic [DIGITS-1:0]   an_q;

    // Scan state: slot counter, descending digit index, and shadow registers.
    // A load on the wrap edge lands together with the index step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt <= '0;
            idx      <= '0;
            val_q    <= '0;
            dp_q     <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (&slot_cnt)
                idx <= (idx == '0) ? LAST : idx - 1'b1;
            if (bus.load) begin
                val_q <= bus.value;
                dp_q  <= bus.dp;
            end
        end
    end

    assign val_shift = val_q >> (4 * int'(idx));
    assign dp_shift  = dp_q >> idx;
    assign nibble    = val_shift[3:0];
    assign an_hot    = DIGITS'(1) << idx;
    assign lit       = (slot_cnt[SCAN_DIV-1 -: 4] <= bus.bright);

    seg7_hex_decode u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

`ifdef SEG7_ZERO_BLANK_EN
    // Everything from this digit upward is zero; the units digit always shows.
    assign blank = (idx != '0) && (val_shift == '0);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_nxt = '0;
        dp_nxt  = 1'b0;
        an_nxt  = '0;
        if (lit) begin
            seg_nxt = blank ? '0 : dec_seg;
            dp_nxt  = dp_shift[0];
            an_nxt  = an_hot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q    <= {7{INV}};
            dp_out_q <= INV;
            an_q     <= {DIGITS{INV}};
        end else begin
            seg_q    <= seg_nxt ^ {7{INV}};
            dp_out_q <= dp_nxt ^ INV;
            an_q     <= an_nxt ^ {DIGITS{INV}};
        end
    end

    assign bus.seg    = seg_q;
    assign bus.dp_out = dp_out_q;
    assign bus.an     = an_q;

endmodule
